micro_div_unit: RTL and testbench

Sequential restoring divider: 8-bit dividend by 4-bit divisor, yielding an 8-bit quotient and 4-bit remainder, one quotient bit per cycle. It is the inverse companion of the team's 4x4 shift-add multiplier. It takes an 8-bit product back down to its factors, and shares the same `sys_clk`/`sys_rst` domain and start/done style of control. A small FSM sequences a shift/compare/subtract datapath.

---
 rtl/micro_div_pkg.sv | 16 +
 rtl/micro_div_unit_if.sv | 26 ++
 rtl/micro_div_step.sv | 24 ++
 rtl/micro_div_unit.sv | 109 ++++++++++
 tb/tb_micro_div_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/micro_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Default widths, FSM state encoding and the divide-by-zero quotient.
package micro_div_pkg;

  localparam int W_DVD_DEF = 8;
  localparam int W_DVS_DEF = 4;

  localparam logic [W_DVD_DEF-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/micro_div_unit_if.sv
// Request/result bundle of the divider: operands and start in, results and status out.
interface micro_div_unit_if #(
  parameter int W_DVD = micro_div_pkg::W_DVD_DEF,
  parameter int W_DVS = micro_div_pkg::W_DVS_DEF
);

  logic             start;
  logic [W_DVD-1:0] dividend;
  logic [W_DVS-1:0] divisor;
  logic [W_DVD-1:0] quotient;
  logic [W_DVS-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div0
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div0
  );

endinterface

// File: rtl/micro_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module micro_div_step #(
  parameter int W_DVS = 4
) (
  input  logic [W_DVS-1:0] rem_i,
  input  logic             bit_i,
  input  logic [W_DVS-1:0] divisor_i,
  output logic [W_DVS-1:0] rem_o,
  output logic             q_o
);

  logic [W_DVS:0]   trial;
  logic [W_DVS-1:0] diff;

  // The compare uses the full W_DVS+1 bits; the subtraction only needs the low bits
  // because the result is known to be below the divisor when it is taken.
  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial[W_DVS-1:0] - divisor_i;
    q_o   = (trial >= {1'b0, divisor_i});
    rem_o = q_o ? diff : trial[W_DVS-1:0];
  end

endmodule

// File: rtl/micro_div_unit.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Working register shifts the dividend out at the top while quotient bits shift in at the bottom.
module micro_div_unit
  import micro_div_pkg::*;
#(
  parameter int W_DVD = W_DVD_DEF,
  parameter int W_DVS = W_DVS_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  micro_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(W_DVD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_DVD - 1);

  state_t           state_q, state_d;
  logic [W_DVD-1:0] work_q, work_d;
  logic [W_DVS-1:0] rem_q, rem_d;
  logic [W_DVS-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W_DVD-1:0] quotient_q, quotient_d;
  logic [W_DVS-1:0] remainder_q, remainder_d;
  logic             div0_q, div0_d;

  logic [W_DVS-1:0] step_rem;
  logic             step_bit;

  micro_div_step #(.W_DVS(W_DVS)) u_step (
    .rem_i     (rem_q),
    .bit_i     (work_q[W_DVD-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            work_d  = bus.dividend;
            dvs_d   = bus.divisor;
            rem_d   = '0;
            cnt_d   = '0;
            div0_d  = 1'b0;
            state_d = ST_CALC;
          end else begin
            quotient_d  = {W_DVD{1'b1}};
            remainder_d = '0;
            div0_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        work_d = {work_q[W_DVD-2:0], step_bit};
        rem_d  = step_rem;
        cnt_d  = cnt_q + CNT_W'(1);
        // Results land in the output registers on the last step so they are valid with done.
        if (cnt_q == CNT_LAST) begin
          quotient_d  = {work_q[W_DVD-2:0], step_bit};
          remainder_d = step_rem;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div0      = div0_q;
  assign bus.busy      = (state_q == ST_CALC);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_micro_div_unit.sv
// Self-checking bench for micro_div_unit: expected results queued at start, popped at done.
module tb_micro_div_unit;
  import micro_div_pkg::*;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       d0;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  exp_t sb[$];

  micro_div_unit_if #(.W_DVD(8), .W_DVS(4)) bus ();

  micro_div_unit #(.W_DVD(8), .W_DVS(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = DIV0_QUOTIENT; e.r = 4'd0; e.d0 = 1'b1;
    end else begin
      e.q = 8'(a / b); e.r = 4'(a % b); e.d0 = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Called one step after a posedge; returns one step after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b, input bit push);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) sb.push_back(model(int'(a), int'(b)));
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  // lat counts the current cycle as 1; returns one cycle after the done cycle.
  task automatic wait_done(output int lat, output int busy_n, output bit seen,
                           output logic [7:0] q, output logic [3:0] r, output logic d0);
    lat = 1; busy_n = 0; seen = 1'b0; q = '0; r = '0; d0 = 1'b0;
    while (!seen && lat <= 20) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1; q = bus.quotient; r = bus.remainder; d0 = bus.div0;
      end else begin
        if (bus.busy === 1'b1) busy_n++;
        tick();
        lat++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 4'd0;
    repeat (3) tick();
    checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got %0d exp 0", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL reset_remainder got %0d exp 0", bus.remainder); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", bus.div0); end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] a_tab [4] = '{8'd200, 8'd255, 8'd5,  8'd225};
    logic [3:0] b_tab [4] = '{4'd7,   4'd1,   4'd9,  4'd15};
    logic [7:0] q_tab [4] = '{8'd28,  8'd255, 8'd0,  8'd15};
    logic [3:0] r_tab [4] = '{4'd4,   4'd0,   4'd5,  4'd0};
    int lat, busy_n; bit seen; logic [7:0] q; logic [3:0] r; logic d0; exp_t e;
    for (int i = 0; i < 4; i++) begin
      start_op(a_tab[i], b_tab[i], 1'b1);
      wait_done(lat, busy_n, seen, q, r, d0);
      e = sb.pop_front();
      checks++; if (!seen) begin errors++; $display("FAIL basic_done_seen op %0d/%0d got none exp pulse", a_tab[i], b_tab[i]); end
      checks++; if (q !== q_tab[i] || q !== e.q) begin errors++; $display("FAIL basic_quotient %0d/%0d got %0d exp %0d", a_tab[i], b_tab[i], q, q_tab[i]); end
      checks++; if (r !== r_tab[i] || r !== e.r) begin errors++; $display("FAIL basic_remainder %0d/%0d got %0d exp %0d", a_tab[i], b_tab[i], r, r_tab[i]); end
      checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL basic_div0 %0d/%0d got %b exp 0", a_tab[i], b_tab[i], d0); end
      checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency %0d/%0d got %0d exp 9", a_tab[i], b_tab[i], lat); end
      checks++; if (busy_n != 8) begin errors++; $display("FAIL basic_busy_cycles %0d/%0d got %0d exp 8", a_tab[i], b_tab[i], busy_n); end
    end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_single_cycle got %b exp 0", bus.done); end
  endtask

  task automatic test_div0();
    int lat, busy_n; bit seen; logic [7:0] q; logic [3:0] r; logic d0; exp_t e;
    start_op(8'd100, 4'd0, 1'b1);
    wait_done(lat, busy_n, seen, q, r, d0);
    e = sb.pop_front();
    checks++; if (!seen || lat != 1) begin errors++; $display("FAIL div0_latency got %0d seen %b exp 1", lat, seen); end
    checks++; if (busy_n != 0) begin errors++; $display("FAIL div0_busy got %0d cycles exp 0", busy_n); end
    checks++; if (q !== e.q || r !== e.r) begin errors++; $display("FAIL div0_result got q=%0h r=%0d exp q=%0h r=%0d", q, r, e.q, e.r); end
    checks++; if (d0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", d0); end
    checks++; if (bus.div0 !== 1'b1) begin errors++; $display("FAIL div0_held got %b exp 1", bus.div0); end
    start_op(8'd10, 4'd3, 1'b1);
    wait_done(lat, busy_n, seen, q, r, d0);
    e = sb.pop_front();
    checks++; if (!seen || q !== 8'd3 || r !== 4'd1 || q !== e.q) begin errors++; $display("FAIL div0_recover got q=%0d r=%0d exp q=3 r=1", q, r); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL div0_clear got %b exp 0", d0); end
  endtask

  task automatic test_ignore_start();
    int lat, busy_n, extra; bit seen; logic [7:0] q; logic [3:0] r; logic d0; exp_t e;
    start_op(8'd50, 4'd6, 1'b1);
    repeat (2) tick();
    bus.start = 1'b1; bus.dividend = 8'd99; bus.divisor = 4'd2;
    tick();
    bus.start = 1'b0;
    wait_done(lat, busy_n, seen, q, r, d0);
    e = sb.pop_front();
    checks++; if (!seen || lat + 3 != 9) begin errors++; $display("FAIL ignore_latency got %0d exp 9", lat + 3); end
    checks++; if (q !== e.q || r !== e.r) begin errors++; $display("FAIL ignore_result got q=%0d r=%0d exp q=%0d r=%0d", q, r, e.q, e.r); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) extra++;
      tick();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_extra_done got %0d exp 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n, dn; bit seen; logic [7:0] q; logic [3:0] r; logic d0; exp_t e;
    start_op(8'd77, 4'd5, 1'b0);
    repeat (3) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    checks++; if (bus.quotient !== 8'd0 || bus.remainder !== 4'd0) begin errors++; $display("FAIL rstmid_results got q=%0d r=%0d exp 0 0", bus.quotient, bus.remainder); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div0 !== 1'b0) begin errors++; $display("FAIL rstmid_status got busy=%b done=%b div0=%b exp 0 0 0", bus.busy, bus.done, bus.div0); end
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) dn++;
      tick();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", dn); end
    // Reset and start together: start must be dropped.
    bus.start = 1'b1; bus.dividend = 8'd60; bus.divisor = 4'd4; sys_rst = 1'b1;
    tick();
    bus.start = 1'b0; sys_rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      tick();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rst_start_dropped got %0d active cycles exp 0", dn); end
    start_op(8'd81, 4'd9, 1'b1);
    wait_done(lat, busy_n, seen, q, r, d0);
    e = sb.pop_front();
    checks++; if (!seen || q !== 8'd9 || r !== 4'd0 || q !== e.q) begin errors++; $display("FAIL rstmid_fresh got q=%0d r=%0d exp q=9 r=0", q, r); end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n; bit seen; logic [7:0] q; logic [3:0] r; logic d0; exp_t e;
    bus.start = 1'b1; bus.dividend = 8'd20; bus.divisor = 4'd3;
    sb.push_back(model(20, 3));
    sb.push_back(model(20, 3));
    tick();
    wait_done(lat, busy_n, seen, q, r, d0);
    e = sb.pop_front();
    checks++; if (!seen || lat != 9 || q !== e.q || r !== e.r) begin errors++; $display("FAIL b2b_first got lat=%0d q=%0d r=%0d exp lat=9 q=%0d r=%0d", lat, q, r, e.q, e.r); end
    wait_done(lat, busy_n, seen, q, r, d0);
    bus.start = 1'b0;
    e = sb.pop_front();
    checks++; if (!seen || lat != 10 || busy_n != 8) begin errors++; $display("FAIL b2b_gap got lat=%0d busy=%0d exp lat=10 busy=8", lat, busy_n); end
    checks++; if (q !== e.q || r !== e.r) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d exp q=%0d r=%0d", q, r, e.q, e.r); end
    repeat (2) tick();
  endtask

  task automatic test_sweep();
    int lat, busy_n; bit seen; logic [7:0] q; logic [3:0] r; logic d0; exp_t e;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(8'(a), 4'(b), 1'b1);
        wait_done(lat, busy_n, seen, q, r, d0);
        e = sb.pop_front();
        checks++;
        if (!seen || int'(q) * b + int'(r) != a || int'(r) >= b || q !== e.q || d0 !== 1'b0) begin
          errors++;
          $display("FAIL sweep %0d/%0d got q=%0d r=%0d div0=%b exp q=%0d r=%0d div0=0", a, b, q, r, d0, e.q, e.r);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 4'd0;
    #1;
    test_reset();
    test_basic();
    test_div0();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
